// File: rtl/sync_fifo_core_pkg.sv
// Shared constants and helpers for the sync FIFO slice and its stream generator.
package sync_fifo_core_pkg;

   localparam int unsigned FIFO_WIDTH_DEF = 32;
   localparam int unsigned FIFO_DEPTH_DEF = 4;
   localparam logic [31:0] XS_SEED        = 32'h0000_0001;

   // One xorshift32 step (shifts 13, 17, 5).
   function automatic logic [31:0] xorshift_next(input logic [31:0] x);
      logic [31:0] y;
      y = x;
      y = y ^ (y << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// WIDTH x DEPTH storage: synchronous write port, combinational read port, no reset.
module sync_fifo_ram
   import sync_fifo_core_pkg::*;
#(
   parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/xorshift32.sv
// xorshift32 stream source; data is the current state, advanced on each ready cycle.
module xorshift32
   import sync_fifo_core_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        ready,
   output logic [31:0] data
);

   logic [31:0] state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= XS_SEED;
      end else if (ready) begin
         state_q <= xorshift_next(state_q);
      end
   end

   assign data = state_q;

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock show-ahead valid/ready FIFO; flags derive only from registered pointers.
module sync_fifo_core
   import sync_fifo_core_pkg::*;
#(
   parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             rd_ready
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned ADDR = AW + 1;

   logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
   logic            empty, full;
   logic            wr_fire, rd_fire;

   // Extra pointer MSB separates "full" from "empty" when the address bits match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[ADDR-1] != rd_ptr_q[ADDR-1]);

   assign wr_ready = !full;
   assign rd_valid = !empty;
   assign wr_fire  = wr_valid && !full;
   assign rd_fire  = rd_ready && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_fire) wr_ptr_d = wr_ptr_q + ADDR'(1);
      if (rd_fire) rd_ptr_d = rd_ptr_q + ADDR'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   sync_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (wr_fire && !reset),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (wr_data),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (rd_data)
   );

endmodule

// File: tb/tb_sync_fifo_core.sv
// Self-checking bench for sync_fifo_core: queue model compared every cycle plus directed literals.
module tb_sync_fifo_core;

   localparam int W = 32;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] wr_data_drv = '0;
   logic [W-1:0] wr_data;
   logic         wr_valid = 1'b0;
   logic         wr_ready;
   logic [W-1:0] rd_data;
   logic         rd_valid;
   logic         rd_ready = 1'b0;

   logic         stress = 1'b0;
   logic         xs_reset = 1'b1;
   logic [31:0]  xs_wr_data, xs_chk_data;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   assign wr_data = stress ? xs_wr_data : wr_data_drv;

   sync_fifo_core #(.WIDTH(W), .DEPTH(D)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_data  (wr_data),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready)
   );

   xorshift32 u_xs_wr (
      .clk   (clk),
      .reset (xs_reset),
      .ready (stress && wr_valid && wr_ready),
      .data  (xs_wr_data)
   );

   xorshift32 u_xs_chk (
      .clk   (clk),
      .reset (xs_reset),
      .ready (stress && rd_valid && rd_ready),
      .data  (xs_chk_data)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a queue of at most D words; acceptance decided by occupancy before the edge.
   always @(posedge clk) begin
      int n;
      n = exp_q.size();
      if (reset) begin
         exp_q.delete();
      end else begin
         if (rd_ready && n > 0) void'(exp_q.pop_front());
         if (wr_valid && n < D) exp_q.push_back(wr_data);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("rd_valid", W'(rd_valid), W'(exp_q.size() > 0));
         check("wr_ready", W'(wr_ready), W'(exp_q.size() < D));
         if (exp_q.size() > 0) check("rd_data", rd_data, exp_q[0]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [W-1:0] v);
      wr_data_drv = v;
      wr_valid    = 1'b1;
      step();
      wr_valid    = 1'b0;
   endtask

   initial begin
      logic [W-1:0] fill_v [4];
      int sent, rcv;
      fill_v = '{32'h11, 32'h22, 32'h33, 32'h44};

      // Reset
      step();
      chk_en = 1'b1;
      step();
      reset = 1'b0;
      check("reset_rd_valid", W'(rd_valid), W'(0));
      check("reset_wr_ready", W'(wr_ready), W'(1));

      // Fill to full with reads held off
      for (int i = 0; i < 4; i++) write_word(fill_v[i]);
      check("full_wr_ready", W'(wr_ready), W'(0));
      check("full_head", rd_data, 32'h11);
      wr_data_drv = 32'h55;
      wr_valid    = 1'b1;
      step();
      step();
      check("held_wr_ready", W'(wr_ready), W'(0));
      check("held_head", rd_data, 32'h11);
      wr_valid = 1'b0;

      // Drain in order
      rd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_data", rd_data, fill_v[i]);
         step();
         if (i == 0) check("drain_wr_ready", W'(wr_ready), W'(1));
      end
      rd_ready = 1'b0;
      check("drain_empty", W'(rd_valid), W'(0));

      // Write-to-read latency is one edge
      wr_data_drv = 32'hAA;
      wr_valid    = 1'b1;
      check("lat_before", W'(rd_valid), W'(0));
      step();
      wr_valid = 1'b0;
      check("lat_after_valid", W'(rd_valid), W'(1));
      check("lat_after_data", rd_data, 32'hAA);

      // Full with simultaneous write and read: only the read happens on the full cycle
      write_word(32'hB1);
      write_word(32'hB2);
      write_word(32'hB3);
      check("fr_full", W'(wr_ready), W'(0));
      wr_data_drv = 32'hC1;
      wr_valid    = 1'b1;
      rd_ready    = 1'b1;
      step();
      check("fr_read_only_wr_ready", W'(wr_ready), W'(1));
      check("fr_read_only_head", rd_data, 32'hB1);
      step();
      wr_valid = 1'b0;
      check("fr_both_wr_ready", W'(wr_ready), W'(1));
      check("fr_both_head", rd_data, 32'hB2);
      step();
      check("fr_order_b3", rd_data, 32'hB3);
      step();
      check("fr_order_c1", rd_data, 32'hC1);
      step();
      rd_ready = 1'b0;
      check("fr_empty", W'(rd_valid), W'(0));

      // Reset mid-stream overrides a concurrent write and read
      write_word(32'hD1);
      write_word(32'hD2);
      write_word(32'hD3);
      reset       = 1'b1;
      wr_data_drv = 32'hEE;
      wr_valid    = 1'b1;
      rd_ready    = 1'b1;
      step();
      reset    = 1'b0;
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      check("mid_reset_rd_valid", W'(rd_valid), W'(0));
      check("mid_reset_wr_ready", W'(wr_ready), W'(1));
      write_word(32'h77);
      check("post_reset_data", rd_data, 32'h77);
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;

      // Stress: xorshift streams on both sides, random then single-cycle toggle patterns
      xs_reset = 1'b1;
      step();
      xs_reset = 1'b0;
      stress   = 1'b1;
      sent = 0;
      rcv  = 0;
      for (int cyc = 0; cyc < 500 && rcv < 128; cyc++) begin
         if (cyc < 150) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            rd_ready = ($urandom_range(0, 3) != 0);
         end else if (((cyc / 40) % 2) == 0) begin
            wr_valid = 1'b1;
            rd_ready = cyc[0];
         end else begin
            wr_valid = cyc[0];
            rd_ready = 1'b1;
         end
         if (sent >= 128) wr_valid = 1'b0;
         if (rd_valid && rd_ready) begin
            if (rcv == 0) check("xs_first", rd_data, 32'h0000_0001);
            if (rcv == 1) check("xs_second", rd_data, 32'h0004_2021);
            check("xs_stream", rd_data, xs_chk_data);
            rcv++;
         end
         if (wr_valid && wr_ready) sent++;
         step();
      end
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      check("xs_received", W'(rcv), W'(128));
      step();
      check("xs_final_empty", W'(rd_valid), W'(0));

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
